// File: rtl/float_pkg.sv
// Shared types and constants for the float result transmit scheduler.
package float_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SRC,
    FDAT,
    PDAT,
    CSUM,
    GAP
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN   = 5;
  localparam logic       SRC_LO      = 1'b0;
  localparam logic       SRC_HI      = 1'b1;

  // Checksum byte: XOR of header, source id, F and P bytes.
  function automatic logic [7:0] frame_csum(input logic [7:0] hdr, input logic src,
                                            input logic [7:0] f, input logic [2:0] p);
    return hdr ^ {7'b0, src} ^ f ^ {5'b0, p};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the pointer only moves when both requesters compete.
module rr_arb2
  import float_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant_id
);

  logic ptr_reg;

  assign grant_valid = |req;
  assign grant_id    = (req == 2'b11) ? ptr_reg : req[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= SRC_LO;
    end else if (advance && req == 2'b11) begin
      ptr_reg <= ~ptr_reg;
    end
  end

endmodule

// File: rtl/float_tx_scheduler.sv
// Latches float results from two sources and serialises one 5-byte frame per
// request onto a shared UART byte channel, round-robin between sources.
module float_tx_scheduler
  import float_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE   = HDR_DEFAULT,
  parameter int         GAP_CYCLES = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] f_lo,
  input  logic [1:0] p_lo,
  input  logic [7:0] f_hi,
  input  logic [2:0] p_hi,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] req_done,
  output logic       busy,
  output logic       grant_id
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [1:0]       pending;
  logic [7:0]       f_in   [2];
  logic [2:0]       p_in   [2];
  logic [7:0]       f_slot [2];
  logic [2:0]       p_slot [2];
  logic [7:0]       cur_f;
  logic [2:0]       cur_p;
  logic [1:0]       arb_req;
  logic             arb_valid;
  logic             arb_id;
  logic             cs_accept;
  logic             start;

  assign f_in[SRC_LO] = {4'b0, f_lo};
  assign p_in[SRC_LO] = {1'b0, p_lo};
  assign f_in[SRC_HI] = f_hi;
  assign p_in[SRC_HI] = p_hi;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic       pend_reg;
      logic [7:0] f_reg;
      logic [2:0] p_reg;

      // A request arriving while the slot is full is dropped, not queued.
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          pend_reg <= 1'b0;
          f_reg    <= '0;
          p_reg    <= '0;
        end else if (req_done[gi]) begin
          pend_reg <= 1'b0;
        end else if (req_valid[gi] && !pend_reg) begin
          pend_reg <= 1'b1;
          f_reg    <= f_in[gi];
          p_reg    <= p_in[gi];
        end
      end

      assign pending[gi] = pend_reg;
      assign f_slot[gi]  = f_reg;
      assign p_slot[gi]  = p_reg;
    end
  endgenerate

  assign req_ready = ~pending;
  assign cs_accept = (state == CSUM) && tx_ready;
  assign req_done  = cs_accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign cur_f     = f_slot[grant_id];
  assign cur_p     = p_slot[grant_id];

  // The slot finishing this cycle must not be re-picked for a zero-gap restart.
  assign arb_req = pending & ~req_done;
  assign start   = arb_valid && ((state == IDLE) || (cs_accept && GAP_CYCLES == 0));

  rr_arb2 u_arb (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .req         (arb_req),
    .advance     (start),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR;
            grant_id <= arb_id;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= HDR_BYTE;
          end
        end
        HDR: if (tx_ready) begin
          state   <= SRC;
          tx_data <= {7'b0, grant_id};
        end
        SRC: if (tx_ready) begin
          state   <= FDAT;
          tx_data <= cur_f;
        end
        FDAT: if (tx_ready) begin
          state   <= PDAT;
          tx_data <= {5'b0, cur_p};
        end
        PDAT: if (tx_ready) begin
          state   <= CSUM;
          tx_data <= frame_csum(HDR_BYTE, grant_id, cur_f, cur_p);
        end
        CSUM: if (tx_ready) begin
          if (GAP_CYCLES == 0) begin
            if (start) begin
              state    <= HDR;
              grant_id <= arb_id;
              tx_valid <= 1'b1;
              tx_data  <= HDR_BYTE;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_valid <= 1'b0;
              tx_data  <= '0;
            end
          end else begin
            state    <= GAP;
            gap_cnt  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_tx_scheduler.sv
// Directed and randomized checks of float_tx_scheduler against a frame-level model.
module tb_float_tx_scheduler;

  localparam int GAP = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_valid_z = 2'b00;
  logic [3:0] f_lo = '0;
  logic [1:0] p_lo = '0;
  logic [7:0] f_hi = '0;
  logic [2:0] p_hi = '0;
  logic       tx_ready = 1'b0;
  logic       tx_ready_z = 1'b0;

  logic [1:0] req_ready, req_done, req_ready_z, req_done_z;
  logic [7:0] tx_data, tx_data_z;
  logic       tx_valid, busy, grant_id, tx_valid_z, busy_z, grant_id_z;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [1:0] expd_q[$];
  logic [1:0] gotd_q[$];
  bit mptr;

  always #5 sys_clk = ~sys_clk;

  float_tx_scheduler #(.HDR_BYTE(8'hA5), .GAP_CYCLES(GAP)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready),
    .f_lo(f_lo), .p_lo(p_lo), .f_hi(f_hi), .p_hi(p_hi),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .req_done(req_done), .busy(busy), .grant_id(grant_id)
  );

  float_tx_scheduler #(.HDR_BYTE(8'hA5), .GAP_CYCLES(0)) dut_z (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid_z), .req_ready(req_ready_z),
    .f_lo(f_lo), .p_lo(p_lo), .f_hi(f_hi), .p_hi(p_hi),
    .tx_data(tx_data_z), .tx_valid(tx_valid_z), .tx_ready(tx_ready_z),
    .req_done(req_done_z), .busy(busy_z), .grant_id(grant_id_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference frame: header, source id, F, P, XOR of the first four.
  function automatic void push_frame(input bit src, input logic [7:0] f, input logic [2:0] p);
    logic [7:0] b [5];
    b[0] = 8'hA5;
    b[1] = {7'b0, src};
    b[2] = f;
    b[3] = {5'b0, p};
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(b[k]);
      expd_q.push_back(k == 4 ? (src ? 2'b10 : 2'b01) : 2'b00);
    end
  endfunction

  function automatic void push_bytes(input logic [39:0] v, input logic [1:0] d);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(v[39-8*k -: 8]);
      expd_q.push_back(k == 4 ? d : 2'b00);
    end
  endfunction

  task automatic run_round(input string tag, input int stagger_at, input bit sb,
                           input logic [7:0] sf, input logic [2:0] sp, input bit rnd);
    bit         done = 1'b0;
    bit         stall = 1'b0;
    logic [7:0] stall_data = '0;
    int         n;
    got_q.delete();
    gotd_q.delete();
    for (int c = 1; c <= 400 && !done; c++) begin
      cyc();
      if (stall) begin
        chk({tag, "_hold_valid"}, tx_valid, 1'b1);
        chk({tag, "_hold_data"}, tx_data, stall_data);
      end
      req_valid = 2'b00;
      if (c == stagger_at) begin
        req_valid[sb] = 1'b1;
        if (sb) begin f_hi = sf; p_hi = sp; end
        else begin f_lo = sf[3:0]; p_lo = sp[1:0]; end
      end else begin
        f_lo = 4'($urandom_range(0, 15));
        p_lo = 2'($urandom_range(0, 3));
        f_hi = 8'($urandom_range(0, 255));
        p_hi = 3'($urandom_range(0, 7));
        if (rnd && busy && $urandom_range(0, 3) == 0) req_valid = ~req_ready;
      end
      tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        gotd_q.push_back(req_done);
      end
      stall = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (c > stagger_at && !busy && req_ready == 2'b11 && !tx_valid) done = 1'b1;
    end
    req_valid = 2'b00;
    chk({tag, "_finished"}, done, 1'b1);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_done%0d", tag, i), gotd_q[i], expd_q[i]);
    end
    exp_q.delete();
    expd_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] v5;
    logic [79:0] v10;
    int          n;
    bit          seen;
    int          kind, stg;
    bit          a;
    logic [3:0]  rfl;
    logic [1:0]  rpl;
    logic [7:0]  rfh, rsf;
    logic [2:0]  rph, rsp;

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b11);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_done", req_done, 2'b00);
    sys_rst = 1'b0;
    cyc();

    // Source 0 single frame with tx_ready tied high
    f_lo = 4'h9; p_lo = 2'd2; tx_ready = 1'b1; req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    chk("t1_ready_drop", req_ready, 2'b10);
    chk("t1_no_valid_yet", tx_valid, 1'b0);
    f_lo = 4'h6; p_lo = 2'd1;
    cyc();
    chk("t1_busy", busy, 1'b1);
    chk("t1_grant", grant_id, 1'b0);
    v5 = 40'hA5_00_09_02_AE;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t1_byte%0d", k), tx_data, v5[39-8*k -: 8]);
      chk($sformatf("t1_valid%0d", k), tx_valid, 1'b1);
      chk($sformatf("t1_done%0d", k), req_done, (k == 4) ? 2'b01 : 2'b00);
      cyc();
    end
    chk("t1_valid_off", tx_valid, 1'b0);
    chk("t1_ready_back", req_ready, 2'b11);
    n = 0;
    while (busy && n < 100) begin cyc(); n++; end
    chk("t1_gap_len", n, GAP);

    // Both sources on the same edge, twice: round-robin order alternates
    f_lo = 4'h3; p_lo = 2'd1; f_hi = 8'hC4; p_hi = 3'd5;
    push_bytes(40'hA5_00_03_01_A7, 2'b01);
    push_bytes(40'hA5_01_C4_05_65, 2'b10);
    req_valid = 2'b11;
    run_round("t2a", -1, 1'b0, 8'h00, 3'd0, 1'b0);
    f_lo = 4'h3; p_lo = 2'd1; f_hi = 8'hC4; p_hi = 3'd5;
    push_bytes(40'hA5_01_C4_05_65, 2'b10);
    push_bytes(40'hA5_00_03_01_A7, 2'b01);
    req_valid = 2'b11;
    run_round("t2b", -1, 1'b0, 8'h00, 3'd0, 1'b0);

    // Backpressure held for three cycles on the F byte
    f_lo = 4'h5; p_lo = 2'd3; tx_ready = 1'b1; req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("t3_hdr", tx_data, 8'hA5);
    cyc();
    chk("t3_src", tx_data, 8'h00);
    cyc();
    chk("t3_f", tx_data, 8'h05);
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("t3_stall_data%0d", k), tx_data, 8'h05);
      chk($sformatf("t3_stall_valid%0d", k), tx_valid, 1'b1);
    end
    tx_ready = 1'b1;
    cyc();
    chk("t3_p", tx_data, 8'h03);
    cyc();
    chk("t3_cs", tx_data, 8'hA3);
    chk("t3_done", req_done, 2'b01);
    cyc();
    chk("t3_valid_off", tx_valid, 1'b0);
    n = 0;
    while (busy && n < 100) begin cyc(); n++; end
    chk("t3_idle", busy, 1'b0);

    // Slot-full request on source 1 is ignored
    f_hi = 8'h11; p_hi = 3'd2; req_valid = 2'b10;
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("t4_hdr", tx_data, 8'hA5);
    f_hi = 8'h77; p_hi = 3'd7; req_valid = 2'b10;
    chk("t4_ready_low", req_ready[1], 1'b0);
    cyc();
    req_valid = 2'b00;
    chk("t4_src", tx_data, 8'h01);
    cyc();
    chk("t4_f", tx_data, 8'h11);
    cyc();
    chk("t4_p", tx_data, 8'h02);
    cyc();
    chk("t4_cs", tx_data, 8'hB7);
    chk("t4_ready_still_low", req_ready[1], 1'b0);
    cyc();
    chk("t4_ready_back", req_ready, 2'b11);
    chk("t4_valid_off", tx_valid, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < GAP + 6; k++) begin cyc(); seen |= tx_valid; end
    chk("t4_single_frame", seen, 1'b0);
    chk("t4_idle", busy, 1'b0);

    // Zero-gap instance: second header follows the checksum immediately
    f_lo = 4'h3; p_lo = 2'd1; f_hi = 8'hC4; p_hi = 3'd5;
    tx_ready_z = 1'b1; req_valid_z = 2'b11;
    cyc();
    req_valid_z = 2'b00;
    cyc();
    v10 = 80'hA5_00_03_01_A7_A5_01_C4_05_65;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t6_byte%0d", k), tx_data_z, v10[79-8*k -: 8]);
      chk($sformatf("t6_valid%0d", k), tx_valid_z, 1'b1);
      chk($sformatf("t6_done%0d", k), req_done_z,
          (k == 4) ? 2'b01 : ((k == 9) ? 2'b10 : 2'b00));
      cyc();
    end
    chk("t6_valid_off", tx_valid_z, 1'b0);
    chk("t6_busy_off", busy_z, 1'b0);
    chk("t6_ready_back", req_ready_z, 2'b11);

    // Asynchronous reset in the middle of the P byte
    f_hi = 8'h3C; p_hi = 3'd6; tx_ready = 1'b1; req_valid = 2'b10;
    cyc();
    req_valid = 2'b00;
    repeat (4) cyc();
    chk("t5_p", tx_data, 8'h06);
    chk("t5_grant", grant_id, 1'b1);
    #2 sys_rst = 1'b1;
    #1;
    chk("t5_valid_drop", tx_valid, 1'b0);
    chk("t5_busy_drop", busy, 1'b0);
    chk("t5_done_drop", req_done, 2'b00);
    chk("t5_ready", req_ready, 2'b11);
    chk("t5_grant_clr", grant_id, 1'b0);
    chk("t5_data_clr", tx_data, 8'h00);
    cyc();
    sys_rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin cyc(); seen |= tx_valid | busy; end
    chk("t5_no_stale", seen, 1'b0);
    chk("t5_ready_after", req_ready, 2'b11);

    // Randomized rounds with stalls, staggered requests and slot-full pulses
    mptr = 1'b0;
    for (int r = 0; r < 20; r++) begin
      kind = $urandom_range(0, 2);
      a    = 1'($urandom_range(0, 1));
      rfl  = 4'($urandom_range(0, 15));
      rpl  = 2'($urandom_range(0, 3));
      rfh  = 8'($urandom_range(0, 255));
      rph  = 3'($urandom_range(0, 7));
      rsf  = 8'($urandom_range(0, 255));
      rsp  = 3'($urandom_range(0, 7));
      f_lo = rfl; p_lo = rpl; f_hi = rfh; p_hi = rph;
      stg  = -1;
      if (kind == 1) begin
        push_frame(mptr, mptr ? rfh : {4'b0, rfl}, mptr ? rph : {1'b0, rpl});
        push_frame(!mptr, !mptr ? rfh : {4'b0, rfl}, !mptr ? rph : {1'b0, rpl});
        mptr = !mptr;
        req_valid = 2'b11;
      end else begin
        push_frame(a, a ? rfh : {4'b0, rfl}, a ? rph : {1'b0, rpl});
        req_valid = a ? 2'b10 : 2'b01;
        if (kind == 2) begin
          stg = $urandom_range(1, 6);
          push_frame(!a, !a ? rsf : {4'b0, rsf[3:0]}, !a ? rsp : {1'b0, rsp[1:0]});
        end
      end
      run_round($sformatf("rnd%0d", r), stg, !a, rsf, rsp, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
